// File: rtl/otfs_grid_reader.sv
// rtl/otfs_grid_reader.sv - delay-Doppler frame buffer read controller with credit FIFO
// Define GRID_READER_OREG_EN when the RAM port B has an output register (latency 2, depth 5).
module otfs_grid_reader #(
  parameter int LOG_M  = 6,
  parameter int LOG_N  = 6,
  parameter int DATA_W = 32,
  parameter int ADDR_W = LOG_M + LOG_N
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic              transpose,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

`ifdef GRID_READER_OREG_EN
  localparam int LAT   = 2;
  localparam int DEPTH = 5;
`else
  localparam int LAT   = 1;
  localparam int DEPTH = 4;
`endif
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = 3;
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state;
  logic              tr_q;
  logic [LOG_M-1:0]  r_cnt;
  logic [LOG_N-1:0]  c_cnt;
  logic              is_last;

  logic [LAT-1:0]    pipe_v;
  logic [LAT-1:0]    pipe_last;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W:0]    credit_used;

  logic [DATA_W-1:0] mem      [DEPTH];
  logic              mem_last [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  assign is_last = (&r_cnt) & (&c_cnt);
  assign addrb   = {r_cnt, c_cnt};
  assign busy    = (state != S_IDLE);

  assign m_valid = (count != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign m_last  = m_valid & mem_last[rd_ptr];
  assign pop     = m_valid & m_ready;
  assign push    = pipe_v[LAT-1];
  assign done    = pop & m_last;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + CNT_W'(pipe_v[i]);
    end
  end

  // Reads in flight plus buffered entries, less the beat leaving now, must fit the FIFO.
  assign credit_used = {1'b0, inflight} + {1'b0, count} - {{CNT_W{1'b0}}, pop};
  assign rd_en       = (state == S_ISSUE) && (credit_used < CREDIT_MAX);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_IDLE;
      tr_q  <= 1'b0;
      r_cnt <= '0;
      c_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ISSUE;
            tr_q  <= transpose;
            r_cnt <= '0;
            c_cnt <= '0;
          end
        end
        S_ISSUE: begin
          if (rd_en) begin
            // Counters freeze on the final read so addrb holds afterwards.
            if (is_last) begin
              state <= S_DRAIN;
            end else if (!tr_q) begin
              if (&c_cnt) begin
                c_cnt <= '0;
                r_cnt <= r_cnt + LOG_M'(1);
              end else begin
                c_cnt <= c_cnt + LOG_N'(1);
              end
            end else begin
              if (&r_cnt) begin
                r_cnt <= '0;
                c_cnt <= c_cnt + LOG_N'(1);
              end else begin
                r_cnt <= r_cnt + LOG_M'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          if (done) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pipe_v    <= '0;
      pipe_last <= '0;
    end else begin
      pipe_v[0]    <= rd_en;
      pipe_last[0] <= rd_en & is_last;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr]      <= doutb;
      mem_last[wr_ptr] <= pipe_last[LAT-1];
    end
  end

endmodule

// File: tb/tb_otfs_grid_reader.sv
// tb/tb_otfs_grid_reader.sv - randomized self-checking bench for otfs_grid_reader with a RAM model
module tb_otfs_grid_reader;
  localparam int M  = 64;
  localparam int N  = 64;
  localparam int MN = M * N;
`ifdef GRID_READER_OREG_EN
  localparam int LAT   = 2;
  localparam int DEPTH = 5;
`else
  localparam int LAT   = 1;
  localparam int DEPTH = 4;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        start = 1'b0;
  logic        transpose = 1'b0;
  logic        busy, done, rd_en, m_valid, m_last;
  logic        m_ready = 1'b0;
  logic [11:0] addrb;
  logic [31:0] doutb, m_data;

  logic [31:0] ram [0:MN-1];
  logic [31:0] q1;

  int total = 0;
  int bad   = 0;

  logic [31:0] got[$];
  int cyc, first_valid, last_cyc, last_idx, n_last, n_done, done_bad, stab_err;
  int issued, popped, max_occ;
  bit prev_hold;
  logic [31:0] prev_data;
  logic prev_last;
  logic c1_busy, c1_rd;
  logic [11:0] c1_addr;

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (rd_en) q1 <= ram[addrb];
  end
`ifdef GRID_READER_OREG_EN
  logic [31:0] q2;
  always @(posedge Clk) q2 <= q1;
  assign doutb = q2;
`else
  assign doutb = q1;
`endif

  otfs_grid_reader #(.LOG_M(6), .LOG_N(6), .DATA_W(32), .ADDR_W(12)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .transpose(transpose),
    .busy(busy), .done(done), .rd_en(rd_en), .addrb(addrb), .doutb(doutb),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  function automatic logic [31:0] exp_word(bit t, int b);
    if (!t) return ram[b];
    return ram[(b % M) * N + (b / M)];
  endfunction

  function automatic int data_errs(bit t);
    int e = 0;
    for (int b = 0; b < MN; b++)
      if (b >= got.size() || got[b] !== exp_word(t, b)) e++;
    return e;
  endfunction

  task automatic preload(input bit rnd);
    for (int k = 0; k < MN; k++)
      ram[k] = rnd ? $urandom : 32'hA5A5A5A5 + 32'(k);
  endtask

  task automatic step();
    @(negedge Clk);
    cyc++;
    if (cyc == 1) begin
      c1_busy = busy; c1_rd = rd_en; c1_addr = addrb;
    end
    if (prev_hold && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stab_err++;
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (rd_en) issued++;
    if (done && !(m_valid && m_ready && m_last)) done_bad++;
    if (done) n_done++;
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      popped++;
      if (m_last) begin
        n_last++; last_idx = got.size() - 1; last_cyc = cyc;
      end
    end
    if (issued - popped > max_occ) max_occ = issued - popped;
    prev_hold = m_valid && !m_ready;
    prev_data = m_data;
    prev_last = m_last;
    @(posedge Clk); #1;
  endtask

  task automatic start_frame(input bit t);
    got.delete();
    first_valid = -1; last_cyc = -1; last_idx = -1;
    n_last = 0; n_done = 0; done_bad = 0; stab_err = 0;
    issued = 0; popped = 0; max_occ = 0; prev_hold = 0;
    start = 1'b1; transpose = t; cyc = -1;
    step();
    start = 1'b0;
    transpose = 1'($urandom_range(0, 1));
  endtask

  task automatic run_frame(input bit rnd, output bit to);
    to = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (n_done > 0) begin
        to = 1'b0;
        break;
      end
    end
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; start = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    total += 7;
    if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    if (rd_en !== 1'b0)   begin bad++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
    if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    if (m_last !== 1'b0)  begin bad++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
    if (addrb !== 12'h0)  begin bad++; $display("FAIL reset_addrb got=%h exp=0", addrb); end
    if (m_data !== 32'h0) begin bad++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
  endtask

  task automatic test_row_major();
    bit to;
    int e;
    preload(1'b0);
    start_frame(1'b0);
    run_frame(1'b0, to);
    e = data_errs(1'b0);
    total += 13;
    if (to) begin bad++; $display("FAIL row_timeout got=timeout exp=done"); end
    if (c1_busy !== 1'b1) begin bad++; $display("FAIL row_c1_busy got=%b exp=1", c1_busy); end
    if (c1_rd !== 1'b1)   begin bad++; $display("FAIL row_c1_rd_en got=%b exp=1", c1_rd); end
    if (c1_addr !== 12'h0) begin bad++; $display("FAIL row_c1_addrb got=%h exp=0", c1_addr); end
    if (first_valid != LAT + 2) begin bad++; $display("FAIL row_first_valid got=%0d exp=%0d", first_valid, LAT + 2); end
    if (got.size() != MN) begin bad++; $display("FAIL row_beats got=%0d exp=%0d", got.size(), MN); end
    if (e != 0) begin bad++; $display("FAIL row_data got=%0d errors exp=0", e); end
    if (n_last != 1) begin bad++; $display("FAIL row_last_count got=%0d exp=1", n_last); end
    if (last_idx != MN - 1) begin bad++; $display("FAIL row_last_idx got=%0d exp=%0d", last_idx, MN - 1); end
    if (n_done != 1) begin bad++; $display("FAIL row_done_count got=%0d exp=1", n_done); end
    if (done_bad != 0) begin bad++; $display("FAIL row_done_align got=%0d exp=0", done_bad); end
    if (last_cyc != MN + LAT + 1) begin bad++; $display("FAIL row_last_cycle got=%0d exp=%0d", last_cyc, MN + LAT + 1); end
    if (busy !== 1'b0) begin bad++; $display("FAIL row_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_transpose();
    bit to;
    int e;
    preload(1'b0);
    start_frame(1'b1);
    run_frame(1'b0, to);
    e = data_errs(1'b1);
    total += 5;
    if (to) begin bad++; $display("FAIL tr_timeout got=timeout exp=done"); end
    if (got.size() != MN) begin bad++; $display("FAIL tr_beats got=%0d exp=%0d", got.size(), MN); end
    if (e != 0) begin bad++; $display("FAIL tr_data got=%0d errors exp=0", e); end
    if (n_done != 1) begin bad++; $display("FAIL tr_done_count got=%0d exp=1", n_done); end
    if (first_valid != LAT + 2) begin bad++; $display("FAIL tr_first_valid got=%0d exp=%0d", first_valid, LAT + 2); end
    if (got.size() == MN) begin
      total += 6;
      if (got[0] !== 32'hA5A5A5A5) begin bad++; $display("FAIL tr_beat0 got=%h exp=a5a5a5a5", got[0]); end
      if (got[1] !== 32'hA5A5A5E5) begin bad++; $display("FAIL tr_beat1 got=%h exp=a5a5a5e5", got[1]); end
      if (got[2] !== 32'hA5A5A625) begin bad++; $display("FAIL tr_beat2 got=%h exp=a5a5a625", got[2]); end
      if (got[3] !== 32'hA5A5A665) begin bad++; $display("FAIL tr_beat3 got=%h exp=a5a5a665", got[3]); end
      if (got[64] !== 32'hA5A5A5A6) begin bad++; $display("FAIL tr_beat64 got=%h exp=a5a5a5a6", got[64]); end
      if (got[4095] !== 32'hA5A5B5A4) begin bad++; $display("FAIL tr_beat4095 got=%h exp=a5a5b5a4", got[4095]); end
    end
  endtask

  task automatic test_random_ready();
    bit to;
    int e;
    preload(1'b1);
    start_frame(1'b0);
    run_frame(1'b1, to);
    e = data_errs(1'b0);
    total += 6;
    if (to) begin bad++; $display("FAIL rnd_timeout got=timeout exp=done"); end
    if (got.size() != MN) begin bad++; $display("FAIL rnd_beats got=%0d exp=%0d", got.size(), MN); end
    if (e != 0) begin bad++; $display("FAIL rnd_data got=%0d errors exp=0", e); end
    if (stab_err != 0) begin bad++; $display("FAIL rnd_stable got=%0d violations exp=0", stab_err); end
    if (max_occ > DEPTH) begin bad++; $display("FAIL rnd_occupancy got=%0d exp<=%0d", max_occ, DEPTH); end
    if (n_done != 1 || done_bad != 0) begin bad++; $display("FAIL rnd_done got=%0d/%0d exp=1/0", n_done, done_bad); end
  endtask

  task automatic test_stall();
    bit to;
    int e, rel, stall_beats;
    preload(1'b1);
    m_ready = 1'b0;
    start_frame(1'b0);
    for (int i = 0; i < 50 && first_valid < 0; i++) step();
    repeat (20) step();
    stall_beats = got.size();
    total += 4;
    if (first_valid != LAT + 2) begin bad++; $display("FAIL stall_first_valid got=%0d exp=%0d", first_valid, LAT + 2); end
    if (issued > DEPTH) begin bad++; $display("FAIL stall_reads got=%0d exp<=%0d", issued, DEPTH); end
    if (rd_en !== 1'b0) begin bad++; $display("FAIL stall_rd_en got=%b exp=0", rd_en); end
    if (stall_beats != 0) begin bad++; $display("FAIL stall_beats got=%0d exp=0", stall_beats); end
    rel = cyc + 1;
    run_frame(1'b0, to);
    e = data_errs(1'b0);
    total += 5;
    if (to) begin bad++; $display("FAIL stall_timeout got=timeout exp=done"); end
    if (got.size() != MN) begin bad++; $display("FAIL stall_total got=%0d exp=%0d", got.size(), MN); end
    if (e != 0) begin bad++; $display("FAIL stall_data got=%0d errors exp=0", e); end
    if (stab_err != 0) begin bad++; $display("FAIL stall_stable got=%0d violations exp=0", stab_err); end
    if (last_cyc != rel + MN - 1) begin bad++; $display("FAIL stall_no_gap got=%0d exp=%0d", last_cyc, rel + MN - 1); end
  endtask

  task automatic test_restart_and_reset();
    bit to, pulsed;
    int e;
    preload(1'b1);
    start_frame(1'b0);
    pulsed = 1'b0;
    to = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      start = (!pulsed && got.size() == 100);
      if (start) begin pulsed = 1'b1; transpose = 1'b1; end
      step();
      start = 1'b0;
      if (n_done > 0) begin to = 1'b0; break; end
    end
    e = data_errs(1'b0);
    total += 4;
    if (to) begin bad++; $display("FAIL ign_timeout got=timeout exp=done"); end
    if (e != 0) begin bad++; $display("FAIL ign_data got=%0d errors exp=0", e); end
    if (n_done != 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", n_done); end
    if (got.size() != MN) begin bad++; $display("FAIL ign_beats got=%0d exp=%0d", got.size(), MN); end

    start_frame(1'b0);
    for (int i = 0; i < 1000 && got.size() < 200; i++) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    total += 8;
    if (n_done != 0) begin bad++; $display("FAIL rst_early_done got=%0d exp=0", n_done); end
    if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (done !== 1'b0)    begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    if (rd_en !== 1'b0)   begin bad++; $display("FAIL rst_rd_en got=%b exp=0", rd_en); end
    if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    if (m_last !== 1'b0)  begin bad++; $display("FAIL rst_m_last got=%b exp=0", m_last); end
    if (addrb !== 12'h0)  begin bad++; $display("FAIL rst_addrb got=%h exp=0", addrb); end
    if (m_data !== 32'h0) begin bad++; $display("FAIL rst_m_data got=%h exp=0", m_data); end

    start_frame(1'b0);
    run_frame(1'b0, to);
    e = data_errs(1'b0);
    total += 4;
    if (to) begin bad++; $display("FAIL rs_timeout got=timeout exp=done"); end
    if (e != 0) begin bad++; $display("FAIL rs_data got=%0d errors exp=0", e); end
    if (n_done != 1) begin bad++; $display("FAIL rs_done_count got=%0d exp=1", n_done); end
    if (first_valid != LAT + 2) begin bad++; $display("FAIL rs_first_valid got=%0d exp=%0d", first_valid, LAT + 2); end
  endtask

  initial begin
    test_reset();
    test_row_major();
    test_transpose();
    test_random_ready();
    test_stall();
    test_restart_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
